// File: rtl/md_pkg.sv
// ---------------------------------------------------------------------------
// md_pkg
// Shared types and constants for the RV32M divide sequencer.
//   div_op_e    : funct3[1:0] encoding of DIV / DIVU / REM / REMU
//   div_state_e : sequencer FSM states
//   XLEN_C      : operand/result width
//   CNT_W_C     : iteration counter width
//   DIV0_QUOT   : quotient returned for a divide by zero (all ones)
// ---------------------------------------------------------------------------
package md_pkg;

    localparam int XLEN_C  = 32;
    localparam int CNT_W_C = $clog2(XLEN_C);

    localparam logic [XLEN_C-1:0] DIV0_QUOT = '1;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } div_state_e;

endpackage

// File: rtl/div_restore_step.sv
// ---------------------------------------------------------------------------
// div_restore_step
// One combinational iteration of radix-2 restoring division.
// The quotient register initially holds the dividend; each step shifts its
// MSB into the partial remainder and shifts the new quotient bit into its LSB.
//   rem_i     : partial remainder (always < divisor between steps)
//   quot_i    : remaining dividend bits / quotient bits built so far
//   divisor_i : divisor magnitude
//   rem_o     : next partial remainder
//   quot_o    : next quotient register value
// ---------------------------------------------------------------------------
module div_restore_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quot_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quot_o
);

    logic [XLEN:0]   shifted;
    logic [XLEN+1:0] diff;
    logic            unused_diff_bit;

    // The shifted remainder can reach 2*divisor-1, so it needs one extra bit;
    // the difference gets a further bit so its MSB is a clean borrow flag.
    always_comb begin
        shifted = {rem_i, quot_i[XLEN-1]};
        diff    = {1'b0, shifted} - {2'b00, divisor_i};
        if (diff[XLEN+1]) begin
            // Borrow: keep the shifted value (restore) and record a 0 bit.
            rem_o  = shifted[XLEN-1:0];
            quot_o = {quot_i[XLEN-2:0], 1'b0};
        end else begin
            rem_o  = diff[XLEN-1:0];
            quot_o = {quot_i[XLEN-2:0], 1'b1};
        end
    end

    // When no borrow occurs the result is below the divisor, so bit XLEN is 0.
    assign unused_diff_bit = diff[XLEN];

endmodule

// File: rtl/div_sequencer.sv
// ---------------------------------------------------------------------------
// div_sequencer
// Multi-cycle RV32M DIV/DIVU/REM/REMU unit for the EX stage. Operands are
// latched as magnitudes on an accepted start, 32 restoring steps run in CALC,
// and DONE applies the sign fix-up / special cases and pulses valid_o.
//
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   start_i       : div/rem op present in EX (sampled only in IDLE)
//   op_i          : 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend_i    : rs1 after forwarding
//   divisor_i     : rs2 after forwarding
//   flush_i       : EX flush; aborts an op in flight
//   stall_o       : hold PC, IF/ID and ID/EX
//   busy_o        : state != IDLE
//   valid_o       : one-cycle result strobe
//   result_o      : quotient or remainder, 0 when valid_o is low
//
// Configuration macro DIV_EARLY_OUT_EN: when defined, divide-by-zero and
// signed overflow go straight from IDLE to DONE (result one cycle after the
// start). Otherwise every op spends the full 32 cycles in CALC and the
// special-case results are selected in DONE.
// ---------------------------------------------------------------------------
module div_sequencer
    import md_pkg::*;
#(
    parameter int XLEN  = XLEN_C,
    parameter int CNT_W = CNT_W_C
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            busy_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o
);

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  rem_q, rem_d;
    logic [XLEN-1:0]  quot_q, quot_d;
    logic [XLEN-1:0]  divisor_q, divisor_d;
    logic [XLEN-1:0]  dividend_q, dividend_d;
    div_op_e          op_q, op_d;
    logic             neg_quot_q, neg_quot_d;
    logic             neg_rem_q, neg_rem_d;
    logic             div_zero_q, div_zero_d;
    logic             ovf_q, ovf_d;

    logic             accept;
    logic             in_signed;
    logic             a_neg, b_neg;
    logic [XLEN-1:0]  abs_a, abs_b;
    logic             in_div_zero, in_ovf;
    logic [XLEN-1:0]  step_rem, step_quot;
    logic [XLEN-1:0]  quot_fix, rem_fix, result_fix;

    div_restore_step #(.XLEN(XLEN)) u_step (
        .rem_i     (rem_q),
        .quot_i    (quot_q),
        .divisor_i (divisor_q),
        .rem_o     (step_rem),
        .quot_o    (step_quot)
    );

    // Input-side decode: magnitudes and special-case flags for the op in EX.
    // DIV and REM are the signed ops (funct3[0] == 0).
    always_comb begin
        accept      = (state_q == IDLE) && start_i && !flush_i;
        in_signed   = !op_i[0];
        a_neg       = in_signed && dividend_i[XLEN-1];
        b_neg       = in_signed && divisor_i[XLEN-1];
        abs_a       = a_neg ? (~dividend_i + 1'b1) : dividend_i;
        abs_b       = b_neg ? (~divisor_i + 1'b1) : divisor_i;
        in_div_zero = (divisor_i == '0);
        in_ovf      = in_signed && (dividend_i == MIN_NEG) && (divisor_i == '1);
    end

    // Next-state logic. Flush aborts anything in flight; operands on the
    // inputs are ignored outside the accepting IDLE cycle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quot_d     = quot_q;
        divisor_d  = divisor_q;
        dividend_d = dividend_q;
        op_d       = op_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;
        ovf_d      = ovf_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d    = CALC;
                    cnt_d      = CNT_W'(XLEN - 1);
                    rem_d      = '0;
                    quot_d     = abs_a;
                    divisor_d  = abs_b;
                    dividend_d = dividend_i;
                    op_d       = div_op_e'(op_i);
                    neg_quot_d = a_neg ^ b_neg;
                    neg_rem_d  = a_neg;
                    div_zero_d = in_div_zero;
                    ovf_d      = in_ovf;
`ifdef DIV_EARLY_OUT_EN
                    if (in_div_zero || in_ovf) begin
                        state_d = DONE;
                    end
`endif
                end
            end
            CALC: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else begin
                    rem_d  = step_rem;
                    quot_d = step_quot;
                    cnt_d  = cnt_q - CNT_W'(1);
                    if (cnt_q == '0) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            quot_q     <= '0;
            divisor_q  <= '0;
            dividend_q <= '0;
            op_q       <= DIV;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quot_q     <= quot_d;
            divisor_q  <= divisor_d;
            dividend_q <= dividend_d;
            op_q       <= op_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
            ovf_q      <= ovf_d;
        end
    end

    // Sign fix-up and special cases. Divide-by-zero returns the original
    // dividend as remainder; overflow returns MIN_NEG / 0. Selecting these
    // explicitly keeps the early-out path independent of the CALC datapath.
    always_comb begin
        quot_fix = neg_quot_q ? (~quot_q + 1'b1) : quot_q;
        rem_fix  = neg_rem_q  ? (~rem_q + 1'b1)  : rem_q;
        case (op_q)
            DIV, DIVU: begin
                if (div_zero_q) begin
                    result_fix = DIV0_QUOT;
                end else if (ovf_q) begin
                    result_fix = MIN_NEG;
                end else begin
                    result_fix = quot_fix;
                end
            end
            default: begin
                if (div_zero_q) begin
                    result_fix = dividend_q;
                end else if (ovf_q) begin
                    result_fix = '0;
                end else begin
                    result_fix = rem_fix;
                end
            end
        endcase
    end

    // stall_o includes the accepting IDLE cycle so the op stays in EX, and
    // drops in DONE so the instruction advances together with its result.
    always_comb begin
        busy_o   = (state_q != IDLE);
        stall_o  = accept || (state_q == CALC);
        valid_o  = (state_q == DONE) && !flush_i;
        result_o = valid_o ? result_fix : '0;
    end

endmodule

// File: tb/tb_div_sequencer.sv
// ---------------------------------------------------------------------------
// tb_div_sequencer
// Directed bench for div_sequencer. Inputs change on the falling edge and
// outputs are sampled there too, so the rising edge stays clean. Expected
// latency follows DIV_EARLY_OUT_EN for divide-by-zero and overflow cases.
// ---------------------------------------------------------------------------
module tb_div_sequencer;

    import md_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        flush;
    logic        stall;
    logic        busy;
    logic        valid;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

`ifdef DIV_EARLY_OUT_EN
    localparam int SPECIAL_LAT = 1;
`else
    localparam int SPECIAL_LAT = 33;
`endif

    div_sequencer dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start),
        .op_i       (op),
        .dividend_i (dividend),
        .divisor_i  (divisor),
        .flush_i    (flush),
        .stall_o    (stall),
        .busy_o     (busy),
        .valid_o    (valid),
        .result_o   (result)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison: counts it and reports tag/observed/expected on failure.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drives one start cycle (cycle 0), checks stall is raised in it, then
    // drops start and scrambles the operands so a latched copy is required.
    task automatic applyStimulus(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start    = 1'b1;
        op       = o;
        dividend = a;
        divisor  = b;
        #1;
        checkOutput({tag, " stall@start"}, {31'b0, stall}, 32'd1);
        @(negedge clk);
        start    = 1'b0;
        op       = ~o;
        dividend = 32'h1234_5678;
        divisor  = 32'h0000_0003;
    endtask

    // Full op: start, wait (bounded) for valid, check latency, stall profile,
    // result, then that the unit is idle again the following cycle.
    task automatic runDivision(input string tag, input logic [1:0] o, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] expRes, input int expLat);
        int  lat;
        bit  stallBad;
        applyStimulus(tag, o, a, b);
        lat      = 1;
        stallBad = 1'b0;
        while (valid !== 1'b1 && lat < 40) begin
            if (stall !== 1'b1) stallBad = 1'b1;
            @(negedge clk);
            lat++;
        end
        checkOutput({tag, " latency"}, 32'(lat), 32'(expLat));
        checkOutput({tag, " stall in CALC"}, {31'b0, stallBad}, 32'd0);
        checkOutput({tag, " stall@valid"}, {31'b0, stall}, 32'd0);
        checkOutput({tag, " result"}, result, expRes);
        @(negedge clk);
        checkOutput({tag, " busy after"}, {31'b0, busy}, 32'd0);
        checkOutput({tag, " valid after"}, {31'b0, valid}, 32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        flush    = 1'b0;
        op       = 2'b00;
        dividend = '0;
        divisor  = '0;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("reset stall", {31'b0, stall}, 32'd0);
        checkOutput("reset busy", {31'b0, busy}, 32'd0);
        checkOutput("reset valid", {31'b0, valid}, 32'd0);
        checkOutput("reset result", result, 32'd0);
        rst_n = 1'b1;

        // Basic and signed ops
        runDivision("DIV 100/7", 2'b00, 32'd100, 32'd7, 32'd14, 33);
        runDivision("REM -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        runDivision("DIV -7/2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        runDivision("REMU ffffffff/16", 2'b11, 32'hFFFF_FFFF, 32'd16, 32'd15, 33);
        runDivision("DIV 20/-3", 2'b00, 32'd20, 32'hFFFF_FFFD, 32'hFFFF_FFFA, 33);
        runDivision("REM -20/3", 2'b10, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 33);
        runDivision("DIVU 80000000/3", 2'b01, 32'h8000_0000, 32'd3, 32'h2AAA_AAAA, 33);

        // Divide by zero
        runDivision("DIVU 5/0", 2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, SPECIAL_LAT);
        runDivision("REM 5/0", 2'b10, 32'd5, 32'd0, 32'd5, SPECIAL_LAT);
        runDivision("DIV -9/0", 2'b00, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFFF, SPECIAL_LAT);
        runDivision("REM -9/0", 2'b10, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFF7, SPECIAL_LAT);

        // Signed overflow
        runDivision("DIV ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPECIAL_LAT);
        runDivision("REM ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, SPECIAL_LAT);

        // Flush in IDLE together with start: not accepted, no stall
        @(negedge clk);
        start    = 1'b1;
        flush    = 1'b1;
        op       = 2'b01;
        dividend = 32'd50;
        divisor  = 32'd5;
        #1;
        checkOutput("flush+start stall", {31'b0, stall}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        checkOutput("flush+start busy", {31'b0, busy}, 32'd0);

        // Flush at CALC iteration 10
        applyStimulus("flush op", 2'b01, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        checkOutput("flush pre busy", {31'b0, busy}, 32'd1);
        flush = 1'b1;
        #1;
        checkOutput("flush cycle valid", {31'b0, valid}, 32'd0);
        @(negedge clk);
        flush = 1'b0;
        checkOutput("flush idle busy", {31'b0, busy}, 32'd0);
        checkOutput("flush idle valid", {31'b0, valid}, 32'd0);
        runDivision("DIVU 1000/3 after flush", 2'b01, 32'd1000, 32'd3, 32'd333, 33);

        // Reset mid-CALC
        applyStimulus("reset op", 2'b00, 32'd100, 32'd7);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst stall", {31'b0, stall}, 32'd0);
        checkOutput("midrst busy", {31'b0, busy}, 32'd0);
        checkOutput("midrst valid", {31'b0, valid}, 32'd0);
        checkOutput("midrst result", result, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (valid !== 1'b0 || busy !== 1'b0) begin
                checkOutput("post-reset quiet", {30'b0, busy, valid}, 32'd0);
            end
        end
        runDivision("DIVU 9/3", 2'b01, 32'd9, 32'd3, 32'd3, 33);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
